keccak_state_serializer: RTL and testbench

Parametrised successor to the team's 1600-bit state-to-string packer. It accepts a complete Keccak-f state (25 lanes, any legal lane width), reorders it into string order, and streams it out in OUT_W-bit beats over a valid/ready handshake. Emission can be limited to the first `rate_lanes` lanes for squeeze output. It sits between the permutation core and the digest/squeeze output path.

---
 rtl/keccak_pkg.sv | 30 +++
 rtl/keccak_state_serializer_if.sv | 32 +++
 rtl/keccak_lane_reorder.sv | 22 ++
 rtl/keccak_state_serializer.sv | 101 ++++++++++
 tb/tb_keccak_state_serializer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak constants and helpers.
// Holds the lane count, the largest usable rate, the legal lane widths,
// the string-order lane index helper and the serializer FSM state type.
package keccak_pkg;

  localparam int unsigned NUM_LANES       = 25;
  localparam int unsigned MAX_RATE_LANES  = 25;
  localparam int unsigned NUM_LANE_WIDTHS = 4;
  localparam int unsigned LEGAL_LANE_W [NUM_LANE_WIDTHS] = '{8, 16, 32, 64};

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } ser_state_e;

  // String-order position of lane (x,y); x runs fastest.
  function automatic int unsigned lane_idx(input int unsigned x, input int unsigned y);
    return 5 * y + x;
  endfunction

  function automatic logic lane_w_legal(input int unsigned w);
    logic ok;
    ok = 1'b0;
    for (int unsigned k = 0; k < NUM_LANE_WIDTHS; k++) begin
      if (LEGAL_LANE_W[k] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/keccak_state_serializer_if.sv
// Handshake bundle for keccak_state_serializer.
// Load side: s_valid/s_ready, state_in (x-major matrix order), rate_lanes, abort.
// Stream side: m_valid/m_ready, m_data, m_last.
// slave : serializer view.  master : the view of whatever drives and drains it.
interface keccak_state_serializer_if
  import keccak_pkg::*;
#(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned OUT_W  = 64
);

  logic                        s_valid;
  logic                        s_ready;
  logic [NUM_LANES*LANE_W-1:0] state_in;
  logic [4:0]                  rate_lanes;
  logic                        abort;
  logic                        m_valid;
  logic                        m_ready;
  logic [OUT_W-1:0]            m_data;
  logic                        m_last;

  modport slave (
    input  s_valid, state_in, rate_lanes, abort, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, state_in, rate_lanes, abort, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/keccak_lane_reorder.sv
// Combinational remap of a Keccak state from x-major matrix order
// (lane (x,y) at [(5*x+y)*LANE_W +: LANE_W]) to string order.
// Output places string lane i at the MSB end first, so reading o_string
// from MSB down yields lane 0, lane 1, ... with each lane MSB first.
// Ports: i_state (matrix order), o_string (string order, MSB first).
module keccak_lane_reorder
  import keccak_pkg::*;
#(
  parameter int unsigned LANE_W = 64
) (
  input  logic [NUM_LANES*LANE_W-1:0] i_state,
  output logic [NUM_LANES*LANE_W-1:0] o_string
);

  for (genvar x = 0; x < 5; x++) begin : g_x
    for (genvar y = 0; y < 5; y++) begin : g_y
      assign o_string[(NUM_LANES-1-lane_idx(x, y))*LANE_W +: LANE_W] =
          i_state[(5*x+y)*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/keccak_state_serializer.sv
// Streams a full Keccak-f state out in OUT_W-bit beats, string order,
// limited to the first R lanes (rate_lanes 0 or >25 means all 25).
// Ports: clk, rst_n (async active-low), io_bus (load + stream handshake).
module keccak_state_serializer
  import keccak_pkg::*;
#(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned OUT_W  = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  keccak_state_serializer_if.slave        io_bus
);

  localparam int unsigned SR_W  = NUM_LANES * LANE_W;
  localparam int unsigned CPL   = LANE_W / OUT_W;
  localparam int unsigned CNT_W = $clog2(NUM_LANES * CPL);

  ser_state_e       r_state, w_state_d;
  logic [SR_W-1:0]  r_sr, w_sr_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_last_idx, w_last_idx_d;
  logic             r_last, w_last_d;

  logic [SR_W-1:0]  w_string;
  logic [4:0]       w_rate;
  logic [CNT_W-1:0] w_load_last_idx;
  logic             w_accept;
  logic             w_final;
  logic             w_ready;
  logic             w_load;

  keccak_lane_reorder #(
    .LANE_W (LANE_W)
  ) u_reorder (
    .i_state  (io_bus.state_in),
    .o_string (w_string)
  );

  assign w_rate = (io_bus.rate_lanes == 5'd0 || io_bus.rate_lanes > 5'(MAX_RATE_LANES)) ?
                  5'(MAX_RATE_LANES) : io_bus.rate_lanes;
  assign w_load_last_idx = CNT_W'(32'(w_rate) * CPL - 1);

  assign w_accept = (r_state == StStream) && io_bus.m_ready;
  assign w_final  = w_accept && r_last;
  // Ready during the final accept lets the next state follow with no bubble.
  assign w_ready  = (r_state == StIdle) || w_final;
  assign w_load   = io_bus.s_valid && w_ready;

  assign io_bus.s_ready = w_ready;
  assign io_bus.m_valid = (r_state == StStream);
  assign io_bus.m_data  = r_sr[SR_W-1 -: OUT_W];
  assign io_bus.m_last  = r_last;

  always_comb begin
    w_state_d    = r_state;
    w_sr_d       = r_sr;
    w_cnt_d      = r_cnt;
    w_last_idx_d = r_last_idx;
    w_last_d     = r_last;
    if (io_bus.abort) begin
      // Drop any beat or load presented alongside the abort.
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_last_d  = 1'b0;
    end else if (w_load) begin
      w_state_d    = StStream;
      w_sr_d       = w_string;
      w_cnt_d      = '0;
      w_last_idx_d = w_load_last_idx;
      w_last_d     = (w_load_last_idx == '0);
    end else if (w_accept) begin
      w_sr_d = r_sr << OUT_W;
      if (r_last) begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_last_d  = 1'b0;
      end else begin
        w_cnt_d  = r_cnt + CNT_W'(1);
        w_last_d = ((r_cnt + CNT_W'(1)) == r_last_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_sr       <= w_sr_d;
      r_cnt      <= w_cnt_d;
      r_last_idx <= w_last_idx_d;
      r_last     <= w_last_d;
    end
  end

endmodule

// File: tb/tb_keccak_state_serializer.sv
// Directed bench: three serializer instances (64/64, 64/32, 16/8).
module tb_keccak_state_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  keccak_state_serializer_if #(.LANE_W(64), .OUT_W(64)) ifa ();
  keccak_state_serializer_if #(.LANE_W(64), .OUT_W(32)) ifb ();
  keccak_state_serializer_if #(.LANE_W(16), .OUT_W(8))  ifc ();

  keccak_state_serializer #(.LANE_W(64), .OUT_W(64)) u_a (
    .clk(clk), .rst_n(rst_n), .io_bus(ifa)
  );
  keccak_state_serializer #(.LANE_W(64), .OUT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .io_bus(ifb)
  );
  keccak_state_serializer #(.LANE_W(16), .OUT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .io_bus(ifc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Matrix-order state for instance A: lane (x,y) = {seed, x, y}.
  function automatic logic [25*64-1:0] state_a(input int seed);
    logic [25*64-1:0] s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[(5*x+y)*64 +: 64] = (64'(seed) << 8) | 64'(x*16 + y);
    return s;
  endfunction

  // Expected string lane i of state_a(seed).
  function automatic logic [63:0] lane_a(input int seed, input int i);
    return (64'(seed) << 8) | 64'((i % 5) * 16 + i / 5);
  endfunction

  function automatic logic [25*16-1:0] state_c();
    logic [25*16-1:0] s;
    logic [7:0] h;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        h = 8'(x*16 + y);
        s[(5*x+y)*16 +: 16] = {h, ~h};
      end
    return s;
  endfunction

  function automatic logic [7:0] beat_c(input int j);
    logic [7:0] h;
    h = 8'(((j/2) % 5) * 16 + (j/2) / 5);
    return (j % 2 == 0) ? h : ~h;
  endfunction

  task automatic load_a(input int seed, input logic [4:0] rate);
    ifa.state_in   = state_a(seed);
    ifa.rate_lanes = rate;
    ifa.s_valid    = 1'b1;
    step();
    ifa.s_valid    = 1'b0;
  endtask

  // Checks nbeats beats of a stream with R=r lanes, m_ready held high.
  task automatic stream_a(input int seed, input int r, input int nbeats);
    ifa.m_ready = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      chk("a_valid", ifa.m_valid, 1);
      chk("a_data", ifa.m_data, lane_a(seed, k));
      chk("a_last", ifa.m_last, k == r - 1);
      step();
    end
  endtask

  initial begin
    int got;
    logic stalled;
    logic [7:0] prev;
    logic [25*64-1:0] sb;

    ifa.s_valid = 0; ifa.state_in = '0; ifa.rate_lanes = 0; ifa.abort = 0; ifa.m_ready = 0;
    ifb.s_valid = 0; ifb.state_in = '0; ifb.rate_lanes = 0; ifb.abort = 0; ifb.m_ready = 0;
    ifc.s_valid = 0; ifc.state_in = '0; ifc.rate_lanes = 0; ifc.abort = 0; ifc.m_ready = 0;

    #1;
    chk("rst_a_valid", ifa.m_valid, 0);
    chk("rst_a_last", ifa.m_last, 0);
    chk("rst_a_data", ifa.m_data, 0);
    chk("rst_b_valid", ifb.m_valid, 0);
    chk("rst_b_data", ifb.m_data, 0);
    chk("rst_c_valid", ifc.m_valid, 0);
    chk("rst_c_data", ifc.m_data, 0);
    #20 rst_n = 1'b1;
    step();
    chk("rst_a_ready", ifa.s_ready, 1);

    // Full 25-lane stream, 64-bit beats.
    load_a(0, 5'd25);
    stream_a(0, 25, 25);
    chk("a25_idle", ifa.m_valid, 0);
    chk("a25_ready", ifa.s_ready, 1);

    // Rate 17 then rate 0 (treated as 25).
    load_a(1, 5'd17);
    stream_a(1, 17, 17);
    chk("a17_idle", ifa.m_valid, 0);
    step();
    chk("a17_still_idle", ifa.m_valid, 0);
    load_a(2, 5'd0);
    stream_a(2, 25, 25);
    chk("a0_idle", ifa.m_valid, 0);

    // Rate 31 also means 25.
    load_a(9, 5'd31);
    stream_a(9, 25, 25);
    chk("a31_idle", ifa.m_valid, 0);

    // Back-to-back load during the final beat.
    load_a(3, 5'd2);
    stream_a(3, 2, 1);
    chk("b2b_last", ifa.m_last, 1);
    ifa.state_in   = state_a(4);
    ifa.rate_lanes = 5'd3;
    ifa.s_valid    = 1'b1;
    chk("b2b_ready", ifa.s_ready, 1);
    step();
    ifa.s_valid = 1'b0;
    stream_a(4, 3, 3);
    chk("b2b_idle", ifa.m_valid, 0);

    // Abort at beat 5, with a beat and a load presented in the same cycle.
    load_a(5, 5'd25);
    stream_a(5, 25, 5);
    ifa.abort      = 1'b1;
    ifa.state_in   = state_a(6);
    ifa.s_valid    = 1'b1;
    step();
    ifa.abort   = 1'b0;
    ifa.s_valid = 1'b0;
    chk("abort_valid", ifa.m_valid, 0);
    chk("abort_last", ifa.m_last, 0);
    step();
    chk("abort_dropped", ifa.m_valid, 0);
    load_a(6, 5'd25);
    stream_a(6, 25, 25);
    chk("abort_idle", ifa.m_valid, 0);

    // Reset at beat 5.
    load_a(7, 5'd25);
    stream_a(7, 25, 5);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", ifa.m_valid, 0);
    chk("mrst_data", ifa.m_data, 0);
    chk("mrst_last", ifa.m_last, 0);
    #20 rst_n = 1'b1;
    step();
    chk("mrst_ready", ifa.s_ready, 1);
    chk("mrst_idle", ifa.m_valid, 0);
    load_a(8, 5'd4);
    stream_a(8, 4, 4);
    chk("mrst_end", ifa.m_valid, 0);
    ifa.m_ready = 1'b0;

    // 32-bit beats, single lane.
    for (int i = 0; i < 25; i++) sb[i*64 +: 64] = 64'hFEED_0000_0000_0000 | 64'(i);
    sb[63:0] = 64'h0123_4567_89AB_CDEF;
    ifb.state_in   = sb;
    ifb.rate_lanes = 5'd1;
    ifb.m_ready    = 1'b1;
    ifb.s_valid    = 1'b1;
    step();
    ifb.s_valid = 1'b0;
    chk("b_v0", ifb.m_valid, 1);
    chk("b_d0", ifb.m_data, 32'h0123_4567);
    chk("b_l0", ifb.m_last, 0);
    step();
    chk("b_v1", ifb.m_valid, 1);
    chk("b_d1", ifb.m_data, 32'h89AB_CDEF);
    chk("b_l1", ifb.m_last, 1);
    step();
    chk("b_idle", ifb.m_valid, 0);
    chk("b_ready", ifb.s_ready, 1);
    ifb.m_ready = 1'b0;

    // 16-bit lanes, 8-bit beats, random backpressure.
    ifc.state_in   = state_c();
    ifc.rate_lanes = 5'd0;
    ifc.s_valid    = 1'b1;
    step();
    ifc.s_valid = 1'b0;
    got = 0;
    stalled = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 400 && got < 50; cyc++) begin
      ifc.m_ready = 1'($urandom_range(0, 1));
      chk("c_valid", ifc.m_valid, 1);
      chk("c_data", ifc.m_data, beat_c(got));
      chk("c_last", ifc.m_last, got == 49);
      if (stalled) chk("c_hold", ifc.m_data, prev);
      if (ifc.m_valid && ifc.m_ready) got++;
      stalled = ifc.m_valid && !ifc.m_ready;
      prev    = ifc.m_data;
      step();
    end
    chk("c_count", got, 50);
    ifc.m_ready = 1'b0;
    chk("c_idle", ifc.m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
